wb_register_file: RTL and testbench



---
 rtl/wb_register_file.sv | 127 ++++++++++++
 tb/tb_wb_register_file.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_register_file.sv
// rtl/wb_register_file.sv - write-back stage: result select, 32-entry register file, retired-write counter
//
// Purpose:
//   Selects the write-back value from the MEM/WB pipeline register (load data
//   or ALU result), commits it to a 32 x N general-purpose register file, and
//   offers two combinational read ports to the ID stage. A saturating counter
//   tracks how many register writes have actually been committed.
//
// Optional build macro:
//   WB_BYPASS_EN - when defined, a read port that addresses the register being
//                  written this cycle returns the write-back value before the
//                  commit edge (write-through). When undefined, reads return
//                  stored contents only.
//
// Parameters:
//   N        - register / datapath width
//   SP_RESET - reset value of register 29 ($sp)
//   CNT_W    - width of the retired-write counter
//
// Ports:
//   clk                 in   clock, state updates on rising edge
//   reset               in   asynchronous active-high reset
//   IN_MemRead          in   1 selects load data for write-back
//   IN_RegWrite         in   write enable for this cycle's write-back
//   IN_WriteRegister    in   destination register index
//   IN_DataMemory_Data  in   load data
//   IN_ALUResult        in   ALU result
//   ReadRegister1       in   read port 1 index
//   ReadRegister2       in   read port 2 index
//   OUT_ReadData1       out  read port 1 data
//   OUT_ReadData2       out  read port 2 data
//   OUT_WriteBackData   out  selected write-back value (to forwarding)
//   OUT_RetireCount     out  committed register writes, saturating

module wb_register_file #(
    parameter int           N        = 32,
    parameter logic [N-1:0] SP_RESET = 32'h7FFF_EFFC,
    parameter int           CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IN_MemRead,
    input  logic             IN_RegWrite,
    input  logic [4:0]       IN_WriteRegister,
    input  logic [N-1:0]     IN_DataMemory_Data,
    input  logic [N-1:0]     IN_ALUResult,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [N-1:0]     OUT_ReadData1,
    output logic [N-1:0]     OUT_ReadData2,
    output logic [N-1:0]     OUT_WriteBackData,
    output logic [CNT_W-1:0] OUT_RetireCount
);

    localparam logic [4:0] SP_INDEX = 5'd29;

    logic [N-1:0]     regs [0:31];
    logic [N-1:0]     wb_data;
    logic             commit;
    logic [CNT_W-1:0] retire_count;

    // Write-back select. The commit path below is gated only by IN_RegWrite,
    // so an unknown IN_MemRead on a non-writing cycle never reaches state.
    always_comb begin
        wb_data = IN_ALUResult;
        if (IN_MemRead) begin
            wb_data = IN_DataMemory_Data;
        end
    end

    // A write to register 0 is not a commit: it neither changes state nor
    // counts as a retired write.
    assign commit = IN_RegWrite && (IN_WriteRegister != 5'd0);

    // Register array. Entry 0 is held at zero and never written; reads of
    // index 0 are also forced to zero below, so the entry only keeps the
    // array indexable by the full 5-bit address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == int'(SP_INDEX)) ? SP_RESET : '0;
            end
        end else if (commit) begin
            regs[IN_WriteRegister] <= wb_data;
        end
    end

    // Retired-write counter, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_count <= '0;
        end else if (commit && (retire_count != '1)) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

    // Combinational read ports. Register 0 always reads zero; with the
    // bypass build a same-cycle write to the addressed register is
    // forwarded ahead of the commit edge.
    always_comb begin
        OUT_ReadData1 = '0;
        if (ReadRegister1 != 5'd0) begin
            OUT_ReadData1 = regs[ReadRegister1];
        end
`ifdef WB_BYPASS_EN
        if (commit && (ReadRegister1 == IN_WriteRegister)) begin
            OUT_ReadData1 = wb_data;
        end
`endif
    end

    always_comb begin
        OUT_ReadData2 = '0;
        if (ReadRegister2 != 5'd0) begin
            OUT_ReadData2 = regs[ReadRegister2];
        end
`ifdef WB_BYPASS_EN
        if (commit && (ReadRegister2 == IN_WriteRegister)) begin
            OUT_ReadData2 = wb_data;
        end
`endif
    end

    assign OUT_WriteBackData = wb_data;
    assign OUT_RetireCount   = retire_count;

endmodule

// File: tb/tb_wb_register_file.sv
// tb/tb_wb_register_file.sv - self-checking bench for wb_register_file with a behavioural model
`timescale 1ns/1ps

module tb_wb_register_file;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        reg_write;
    logic [4:0]  write_register;
    logic [31:0] dm_data;
    logic [31:0] alu_result;
    logic [4:0]  read_register1;
    logic [4:0]  read_register2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] wb_data;
    logic [15:0] retire_count;
    logic [31:0] s_read_data1;
    logic [31:0] s_read_data2;
    logic [31:0] s_wb_data;
    logic [3:0]  s_retire_count;

    wb_register_file dut (
        .clk(clk), .reset(reset),
        .IN_MemRead(mem_read), .IN_RegWrite(reg_write),
        .IN_WriteRegister(write_register),
        .IN_DataMemory_Data(dm_data), .IN_ALUResult(alu_result),
        .ReadRegister1(read_register1), .ReadRegister2(read_register2),
        .OUT_ReadData1(read_data1), .OUT_ReadData2(read_data2),
        .OUT_WriteBackData(wb_data), .OUT_RetireCount(retire_count)
    );

    // Narrow-counter instance so saturation is reachable in a few cycles.
    wb_register_file #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .IN_MemRead(mem_read), .IN_RegWrite(reg_write),
        .IN_WriteRegister(write_register),
        .IN_DataMemory_Data(dm_data), .IN_ALUResult(alu_result),
        .ReadRegister1(read_register1), .ReadRegister2(read_register2),
        .OUT_ReadData1(s_read_data1), .OUT_ReadData2(s_read_data2),
        .OUT_WriteBackData(s_wb_data), .OUT_RetireCount(s_retire_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Behavioural model: plain array plus an unbounded commit tally.
    logic [31:0] mregs [32];
    int          mcommits;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_wb();
        return mem_read ? dm_data : alu_result;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (reg_write && write_register != 5'd0 && idx == write_register) return m_wb();
`endif
        return mregs[idx];
    endfunction

    function automatic logic [31:0] m_cnt(input int limit);
        return (mcommits > limit) ? 32'(limit) : 32'(mcommits);
    endfunction

    always @(posedge reset) begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mregs[29] = 32'h7FFF_EFFC;
        mcommits  = 0;
    end

    always @(posedge clk) begin
        if (!reset && reg_write && write_register != 5'd0) begin
            mregs[write_register] = m_wb();
            mcommits++;
        end
    end

    // Compare process: every falling edge, both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wb_data", wb_data, m_wb());
            chk("read1", read_data1, m_read(read_register1));
            chk("read2", read_data2, m_read(read_register2));
            chk("retire_count", 32'(retire_count), m_cnt(65535));
            chk("sat_read1", s_read_data1, m_read(read_register1));
            chk("sat_retire_count", 32'(s_retire_count), m_cnt(15));
        end
    end

    task automatic drive(input logic rw, input logic [4:0] wr, input logic mr,
                         input logic [31:0] dm, input logic [31:0] alu,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        reg_write      = rw;
        write_register = wr;
        mem_read       = mr;
        dm_data        = dm;
        alu_result     = alu;
        read_register1 = r1;
        read_register2 = r2;
    endtask

    initial begin
        reset = 1'b0; mem_read = 1'b0; reg_write = 1'b0; write_register = 5'd0;
        dm_data = 32'h0; alu_result = 32'h0; read_register1 = 5'd0; read_register2 = 5'd0;
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;

        // Reset contents on every index of both ports.
        for (int i = 0; i < 32; i++) begin
            read_register1 = 5'(i);
            read_register2 = 5'(31 - i);
            #1;
            chk("reset_read1", read_data1, (i == 29) ? 32'h7FFF_EFFC : 32'h0);
            chk("reset_read2", read_data2, ((31 - i) == 29) ? 32'h7FFF_EFFC : 32'h0);
        end
        chk("reset_count", 32'(retire_count), 32'd0);

        // ALU result write to register 8.
        drive(1, 5'd8, 0, 32'h0, 32'h0000_1234, 5'd0, 5'd0);
        drive(0, 5'd0, 0, 32'h0, 32'h0, 5'd8, 5'd0);
        #1;
        chk("alu_write_r8", read_data1, 32'h0000_1234);
        chk("count_after_r8", 32'(retire_count), 32'd1);

        // Load data write to register 9.
        drive(1, 5'd9, 1, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd0);
        #1;
        chk("wb_select_load", wb_data, 32'hDEAD_BEEF);
        drive(0, 5'd0, 0, 32'h0, 32'h0, 5'd9, 5'd0);
        #1;
        chk("load_write_r9", read_data1, 32'hDEAD_BEEF);

        // Register 0 discards writes and does not count.
        drive(1, 5'd0, 0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        drive(0, 5'd0, 0, 32'h0, 32'h0, 5'd0, 5'd0);
        #1;
        chk("r0_read1", read_data1, 32'h0);
        chk("r0_read2", read_data2, 32'h0);
        chk("count_after_r0", 32'(retire_count), 32'd2);

        // Same-cycle read of the register being written.
        drive(1, 5'd10, 0, 32'h0, 32'hA5A5_A5A5, 5'd0, 5'd10);
        #1;
`ifdef WB_BYPASS_EN
        chk("same_cycle_r10", read_data2, 32'hA5A5_A5A5);
`else
        chk("same_cycle_r10", read_data2, 32'h0);
`endif
        drive(0, 5'd0, 0, 32'h0, 32'h0, 5'd0, 5'd10);
        #1;
        chk("after_edge_r10", read_data2, 32'hA5A5_A5A5);
        chk("count_after_r10", 32'(retire_count), 32'd3);

        // Asynchronous reset between edges.
        drive(1, 5'd11, 0, 32'h0, 32'hCAFE_0011, 5'd0, 5'd0);
        drive(0, 5'd0, 0, 32'h0, 32'h0, 5'd11, 5'd29);
        #1;
        chk("r11_written", read_data1, 32'hCAFE_0011);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_r11", read_data1, 32'h0);
        chk("async_reset_sp", read_data2, 32'h7FFF_EFFC);
        chk("async_reset_count", 32'(retire_count), 32'd0);
        #1 reset = 1'b0;

        // Saturation of the narrow counter: 14, then two more -> 15.
        for (int i = 0; i < 14; i++) drive(1, 5'(1 + i), 0, 32'h0, 32'(i), 5'd0, 5'd0);
        drive(0, 5'd0, 0, 32'h0, 32'h0, 5'd0, 5'd0);
        #1;
        chk("sat_count_14", 32'(s_retire_count), 32'd14);
        drive(1, 5'd20, 0, 32'h0, 32'h1, 5'd0, 5'd0);
        drive(1, 5'd21, 0, 32'h0, 32'h2, 5'd0, 5'd0);
        drive(0, 5'd0, 0, 32'h0, 32'h0, 5'd0, 5'd0);
        #1;
        chk("sat_count_15", 32'(s_retire_count), 32'd15);
        chk("wide_count_16", 32'(retire_count), 32'd16);
        drive(1, 5'd22, 0, 32'h0, 32'h3, 5'd0, 5'd0);
        drive(0, 5'd0, 0, 32'h0, 32'h0, 5'd0, 5'd0);
        #1;
        chk("sat_holds_15", 32'(s_retire_count), 32'd15);

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int c = 0; c < 600; c++) begin
            logic [4:0] wr;
            logic [4:0] r1;
            logic [4:0] r2;
            wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 3) != 0), wr, 1'($urandom_range(0, 1)),
                  $urandom, $urandom, r1, r2);
            if (c % 97 == 96) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end
        drive(0, 5'd0, 0, 32'h0, 32'h0, 5'd0, 5'd0);
        @(posedge clk);
        @(negedge clk);
        #1 chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
